seq_multiplier: RTL and testbench

- Iterative radix-2 shift-and-add multiplier. It consumes two WIDTH-bit operands and produces a 2*WIDTH-bit product over a fixed number of cycles.
- Sits beside the combinational shift unit, downstream of operand decode, as the ALU's multi-cycle execution stage.
- Valid/ready handshakes on both sides. The operation select uses the same 2-bit opcode style as the shift unit.

---
 rtl/seq_multiplier_pkg.sv | 27 ++
 rtl/seq_multiplier.sv | 139 +++++++++++++
 tb/tb_seq_multiplier.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared ALU definitions for the sequential multiplier: opcodes, FSM state encoding
// and the default operand width.
package seq_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] MUL_U  = 2'b00;
    localparam logic [1:0] MUL_S  = 2'b01;
    localparam logic [1:0] MUL_SU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Opcode 11 is reserved and falls through to unsigned behaviour.
    function automatic logic op_a_signed(input logic [1:0] op);
        return (op == MUL_S) || (op == MUL_SU);
    endfunction

    function automatic logic op_b_signed(input logic [1:0] op);
        return (op == MUL_S);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-and-add multiplier: multiplies operand magnitudes over
// WIDTH steps, then applies the sign in a final fix-up step.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CNT_WIDTH = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [1:0]         i_op,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_result,
    output logic               o_busy
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(WIDTH - 1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic [WIDTH-1:0]       mag_a_q, mag_a_d;
    logic                   neg_q, neg_d;
    logic [2*WIDTH-1:0]     result_q, result_d;
    logic                   valid_q, valid_d;

    logic                   accept;
    logic                   a_neg;
    logic                   b_neg;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic [WIDTH:0]         sum;
    logic [2*WIDTH-1:0]     full_prod;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: if (cnt_q == LAST_CNT) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state_q == IDLE) && !i_rst;
        o_busy  = (state_q == CALC) || (state_q == FIX);
    end

    assign accept = i_valid && (state_q == IDLE);

    // Negating the most-negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    always_comb begin
        a_neg = op_a_signed(i_op) && i_a[WIDTH-1];
        b_neg = op_b_signed(i_op) && i_b[WIDTH-1];
        a_mag = a_neg ? -i_a : i_a;
        b_mag = b_neg ? -i_b : i_b;
    end

    always_comb begin
        sum       = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mag_a_q : '0)};
        full_prod = {hi_q, lo_q};
    end

    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mag_a_d  = mag_a_q;
        neg_d    = neg_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mag_a_d = a_mag;
                    neg_d   = a_neg ^ b_neg;
                    hi_d    = '0;
                    lo_d    = b_mag;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                hi_d  = sum[WIDTH:1];
                lo_d  = {sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
            end
            FIX: begin
                result_d = neg_q ? -full_prod : full_prod;
                valid_d  = 1'b1;
            end
            DONE: begin
                if (i_ready) valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mag_a_q  <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mag_a_q  <= mag_a_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed vectors, random operands against an
// arithmetic reference, backpressure, operand disturbance and asynchronous reset.
module tb_seq_multiplier;
    import seq_multiplier_pkg::*;

    localparam int W = 32;

    logic           i_clk;
    logic           i_rst;
    logic           i_valid;
    logic           o_ready;
    logic [W-1:0]   i_a;
    logic [W-1:0]   i_b;
    logic [1:0]     i_op;
    logic           o_valid;
    logic           i_ready;
    logic [2*W-1:0] o_result;
    logic           o_busy;

    int total;
    int bad;

    seq_multiplier #(.WIDTH(W), .CNT_WIDTH(6)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_op     (i_op),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: sign- or zero-extend each operand to 2*W bits and multiply modulo 2^(2W).
    function automatic logic [2*W-1:0] refMul(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        if (op == 2'b01 || op == 2'b10) ea = {{W{a[W-1]}}, a};
        if (op == 2'b01) eb = {{W{b[W-1]}}, b};
        return ea * eb;
    endfunction

    task automatic checkOutput(input string tag, input logic [2*W-1:0] got,
                               input logic [2*W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int hold, input bit disturb);
        logic [2*W-1:0] expected;
        int waitCnt;
        int edges;
        int busyCnt;
        expected = refMul(op, a, b);
        waitCnt  = 0;
        @(negedge i_clk);
        while (!o_ready && waitCnt < 50) begin
            @(negedge i_clk);
            waitCnt++;
        end
        checkOutput("ready_before_accept", 64'(o_ready), 64'd1);
        i_valid = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        busyCnt = o_busy ? 1 : 0;
        edges   = 0;
        while (edges < 100) begin
            if (disturb && edges < 20) begin
                i_valid = 1'($urandom);
                i_a     = $urandom;
                i_b     = $urandom;
                i_op    = 2'($urandom);
            end else begin
                i_valid = 1'b0;
            end
            @(posedge i_clk);
            #1;
            edges++;
            if (o_busy) busyCnt++;
            if (o_valid) break;
        end
        i_valid = 1'b0;
        checkOutput("latency_edges", 64'(edges), 64'(W + 1));
        checkOutput("busy_cycles", 64'(busyCnt), 64'(W + 1));
        checkOutput("result", o_result, expected);
        for (int i = 0; i < hold; i++) begin
            @(posedge i_clk);
            #1;
            checkOutput("hold_valid", 64'(o_valid), 64'd1);
            checkOutput("hold_result", o_result, expected);
            checkOutput("hold_ready_low", 64'(o_ready), 64'd0);
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        checkOutput("valid_after_handshake", 64'(o_valid), 64'd0);
        checkOutput("ready_after_handshake", 64'(o_ready), 64'd1);
        checkOutput("result_kept", o_result, expected);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        total   = 0;
        bad     = 0;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_op    = 2'b00;
        #1;
        checkOutput("reset_valid", 64'(o_valid), 64'd0);
        checkOutput("reset_result", o_result, 64'd0);
        checkOutput("reset_ready", 64'(o_ready), 64'd0);
        checkOutput("reset_busy", 64'(o_busy), 64'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", 64'(o_ready), 64'd1);

        vecs.push_back('{MUL_U,  32'd3,          32'd5,          64'h000000000000000F});
        vecs.push_back('{MUL_U,  32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001});
        vecs.push_back('{MUL_S,  32'hFFFFFFFF,   32'hFFFFFFFF,   64'h0000000000000001});
        vecs.push_back('{MUL_S,  32'h80000000,   32'h80000000,   64'h4000000000000000});
        vecs.push_back('{MUL_S,  32'h00000007,   32'hFFFFFFFD,   64'hFFFFFFFFFFFFFFEB});
        vecs.push_back('{MUL_SU, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFF00000001});
        vecs.push_back('{2'b11,  32'h00000002,   32'h80000000,   64'h0000000100000000});
        vecs.push_back('{MUL_U,  32'd0,          32'hFFFFFFFF,   64'h0});

        foreach (vecs[i]) begin
            checkOutput("ref_model_vector", refMul(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, (i == 0) ? 10 : 1, i[0]);
        end

        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) ra = 32'h80000000;
            if (i % 7 == 0) rb = 32'h80000000;
            applyStimulus(2'($urandom), ra, rb, $urandom_range(0, 3), 1'($urandom));
        end

        // Abort an operation mid-calculation with an asynchronous reset.
        @(negedge i_clk);
        i_valid = 1'b1;
        i_op    = MUL_U;
        i_a     = 32'h12345678;
        i_b     = 32'h9ABCDEF0;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        checkOutput("abort_valid", 64'(o_valid), 64'd0);
        checkOutput("abort_result", o_result, 64'd0);
        checkOutput("abort_busy", 64'(o_busy), 64'd0);
        checkOutput("abort_ready_in_reset", 64'(o_ready), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        checkOutput("abort_ready_after", 64'(o_ready), 64'd1);
        applyStimulus(MUL_U, 32'd6, 32'd7, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
